// File: rtl/axis_bpsk_demod_ctrl.sv
// BPSK hard-decision demodulator sequencer: slices the data carriers of each OFDM symbol and packs them into bytes.
// Optional macro BPSK_CTRL_MSB_FIRST_EN packs the first data carrier into bit 7 instead of bit 0.
module axis_bpsk_demod_ctrl #(
  parameter int N_SC    = 64,
  parameter int DATA_LO = 4,
  parameter int DATA_HI = 59
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [47:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] sym_count,
  output logic        err_len
);

  localparam int IDX_W = (N_SC > 1) ? $clog2(N_SC) : 1;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sc_idx_q, sc_idx_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic [15:0]        sym_count_q, sym_count_d;
  logic               err_len_q, err_len_d;
  logic               ready_en_q;

  logic               accept_s, out_free_s, in_data_s, at_hi_s, at_end_s;
  logic [2:0]         bit_pos_s;
  logic [7:0]         shreg_v;
  logic [3:0]         cnt_v;
  logic               unused_s;

  assign unused_s   = ^{s_axis_tdata[47:23]};
  assign out_free_s = !m_valid_q || m_axis_tready;
  // ready_en_q holds tready low until the first clock after reset release.
  assign s_axis_tready = ready_en_q && (state_q == ST_RUN) && out_free_s;
  assign accept_s   = s_axis_tvalid && s_axis_tready;
  assign in_data_s  = (sc_idx_q >= IDX_W'(DATA_LO)) && (sc_idx_q <= IDX_W'(DATA_HI));
  assign at_hi_s    = (sc_idx_q == IDX_W'(DATA_HI));
  assign at_end_s   = (sc_idx_q == IDX_W'(N_SC - 1));

`ifdef BPSK_CTRL_MSB_FIRST_EN
  assign bit_pos_s = 3'd7 - bit_cnt_q[2:0];
`else
  assign bit_pos_s = bit_cnt_q[2:0];
`endif

  // Next-state: carrier slicing, byte packing, symbol bookkeeping and output register.
  always_comb begin
    state_d     = state_q;
    sc_idx_d    = sc_idx_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    m_valid_d   = m_valid_q && !m_axis_tready;
    sym_count_d = sym_count_q;
    err_len_d   = err_len_q;
    shreg_v     = shreg_q;
    cnt_v       = bit_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          if (in_data_s) begin
            shreg_v[bit_pos_s] = s_axis_tdata[22];
            cnt_v              = bit_cnt_q + 4'd1;
          end else begin
            cnt_v = bit_cnt_q;
          end

          if (in_data_s && ((cnt_v == 4'd8) || at_hi_s)) begin
            m_data_d  = shreg_v;
            m_valid_d = 1'b1;
            m_last_d  = at_hi_s;
            shreg_d   = 8'd0;
            bit_cnt_d = 4'd0;
          end else if (s_axis_tlast && !at_end_s && (cnt_v != 4'd0)) begin
            // Truncated symbol with a partial byte: emit it padded on a later cycle.
            shreg_d   = shreg_v;
            bit_cnt_d = cnt_v;
            state_d   = ST_FLUSH;
          end else begin
            shreg_d   = shreg_v;
            bit_cnt_d = cnt_v;
          end

          if (s_axis_tlast || at_end_s) begin
            sc_idx_d    = {IDX_W{1'b0}};
            sym_count_d = sym_count_q + 16'd1;
            err_len_d   = err_len_q || !(s_axis_tlast && at_end_s);
          end else begin
            sc_idx_d = sc_idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (out_free_s) begin
          m_data_d  = shreg_q;
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          shreg_d   = 8'd0;
          bit_cnt_d = 4'd0;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_RUN;
      sc_idx_q    <= {IDX_W{1'b0}};
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'd0;
      m_data_q    <= 8'd0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      sym_count_q <= 16'd0;
      err_len_q   <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_idx_q    <= sc_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      sym_count_q <= sym_count_d;
      err_len_q   <= err_len_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign sym_count     = sym_count_q;
  assign err_len       = err_len_q;

endmodule

// File: tb/tb_axis_bpsk_demod_ctrl.sv
// Self-checking bench for axis_bpsk_demod_ctrl: directed table, corner sequences and random traffic against a symbol-level model.
module tb_axis_bpsk_demod_ctrl;
  localparam int N_SC = 64;
  localparam int LO   = 4;
  localparam int HI   = 59;

`ifdef BPSK_CTRL_MSB_FIRST_EN
  localparam logic [7:0] ALT_B = 8'hAA;
  localparam logic [7:0] ONE_B = 8'h80;
  localparam logic [7:0] TWO_B = 8'hC0;
`else
  localparam logic [7:0] ALT_B = 8'h55;
  localparam logic [7:0] ONE_B = 8'h01;
  localparam logic [7:0] TWO_B = 8'h03;
`endif

  logic        aclk, aresetn;
  logic [47:0] s_tdata;
  logic        s_tvalid, s_tlast, m_tready;
  logic        s_tready, m_tvalid, m_tlast, err_len;
  logic [7:0]  m_tdata;
  logic [15:0] sym_count;
  logic        b_s_tready, b_tvalid, b_tlast, b_err;
  logic [7:0]  b_tdata;
  logic [15:0] b_sym;

  axis_bpsk_demod_ctrl #(.N_SC(N_SC), .DATA_LO(LO), .DATA_HI(HI)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .sym_count(sym_count), .err_len(err_len));

  axis_bpsk_demod_ctrl #(.N_SC(N_SC), .DATA_LO(4), .DATA_HI(13)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(b_s_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(b_tdata),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(b_tlast),
    .sym_count(b_sym), .err_len(b_err));

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] got_q[$];
  logic [8:0] got_b[$];
  logic [8:0] exp_q[$];
  int   exp_sym;
  logic exp_err;
  logic rnd_ready = 1'b0;

  typedef struct {
    string      name;
    int         len;
    logic       tl;
    int         mode;
    int         exp_n;
    logic [8:0] exp_first;
    logic [8:0] exp_final;
    logic       exp_err;
  } vec_t;
  vec_t vecs[4];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      if (b_tvalid && m_tready) got_b.push_back({b_tlast, b_tdata});
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rnd_ready) m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 48'd0; m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk);
    #1;
    got_q.delete(); got_b.delete(); exp_q.delete();
    exp_sym = 0; exp_err = 1'b0;
  endtask

  task automatic send(input logic [22:0] re, input logic last);
    int guard = 0;
    s_tdata = {25'd0, re}; s_tvalid = 1'b1; s_tlast = last;
    @(negedge aclk);
    while (!s_tready && guard < 300) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 300) check("send_timeout", 32'(guard), 32'd0);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // Drives one symbol and appends its expected bytes by chunking the data-carrier bits.
  task automatic run_symbol(input int len, input logic tl, input int mode);
    bit bits[$];
    int nb;
    for (int i = 0; i < len; i++) begin
      logic [22:0] re;
      logic [31:0] r;
      r = $urandom;
      case (mode)
        0:       re = (i % 2 == 0) ? -23'sd5 : 23'sd5;
        1:       re = -23'sd1;
        default: re = r[22:0];
      endcase
      if (i >= LO && i <= HI) bits.push_back(re[22]);
      send(re, (i == len - 1) ? tl : 1'b0);
    end
    nb = bits.size();
    for (int k = 0; k < nb; k += 8) begin
      logic [7:0] b;
      logic lastf;
      b = 8'd0;
      for (int j = 0; j < 8; j++) begin
        if (k + j < nb) begin
`ifdef BPSK_CTRL_MSB_FIRST_EN
          b[7 - j] = bits[k + j];
`else
          b[j] = bits[k + j];
`endif
        end
      end
      lastf = (k + 8 >= nb) && ((len > HI) || (nb % 8 != 0));
      exp_q.push_back({lastf, b});
    end
    exp_sym++;
    if (len < N_SC || !tl) exp_err = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    repeat (4) @(negedge aclk);
    while (m_tvalid && guard < 300) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 300) check("drain_timeout", 32'(guard), 32'd0);
    @(negedge aclk);
  endtask

  task automatic compare_model(input string nm);
    check({nm, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({nm, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({nm, "_sym"}, 32'(sym_count), 32'(exp_sym));
    check({nm, "_err"}, 32'(err_len), 32'(exp_err));
  endtask

  initial begin
    vecs[0] = '{"alt64",     64, 1'b1, 0, 7, {1'b0, ALT_B},  {1'b1, ALT_B},  1'b0};
    vecs[1] = '{"early20",   21, 1'b1, 1, 3, {1'b0, 8'hFF},  {1'b1, ONE_B},  1'b1};
    vecs[2] = '{"no_tlast",  64, 1'b0, 1, 7, {1'b0, 8'hFF},  {1'b1, 8'hFF},  1'b1};
    vecs[3] = '{"before_lo",  3, 1'b1, 1, 0, 9'd0,           9'd0,           1'b1};

    aresetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 48'd0; m_tready = 1'b1;
    #3;
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_outs", 32'({m_tvalid, m_tlast, m_tdata, sym_count, err_len}), 32'd0);
    do_reset();
    check("post_rst_tready", 32'(s_tready), 32'd1);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      run_symbol(vecs[v].len, vecs[v].tl, vecs[v].mode);
      drain();
      check({vecs[v].name, "_n"}, 32'(got_q.size()), 32'(vecs[v].exp_n));
      if (got_q.size() > 0 && vecs[v].exp_n > 0) begin
        check({vecs[v].name, "_first"}, 32'(got_q[0]), 32'(vecs[v].exp_first));
        check({vecs[v].name, "_final"}, 32'(got_q[got_q.size() - 1]), 32'(vecs[v].exp_final));
      end
      check({vecs[v].name, "_sym"}, 32'(sym_count), 32'd1);
      check({vecs[v].name, "_err"}, 32'(err_len), 32'(vecs[v].exp_err));
      compare_model(vecs[v].name);
    end

    // Index must restart at 0 after a symbol that ran out without tlast.
    do_reset();
    run_symbol(64, 1'b0, 1);
    run_symbol(5, 1'b1, 1);
    drain();
    check("restart_n", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) check("restart_byte", 32'(got_q[7]), 32'({1'b1, ONE_B}));
    check("restart_sym", 32'(sym_count), 32'd2);
    compare_model("restart");

    // Narrow data window on the second instance.
    do_reset();
    run_symbol(64, 1'b1, 1);
    drain();
    check("narrow_n", 32'(got_b.size()), 32'd2);
    if (got_b.size() == 2) begin
      check("narrow_b0", 32'(got_b[0]), 32'({1'b0, 8'hFF}));
      check("narrow_b1", 32'(got_b[1]), 32'({1'b1, TWO_B}));
    end

    // Backpressure: downstream stalls 10 cycles after the first byte.
    do_reset();
    fork
      run_symbol(64, 1'b1, 0);
      begin
        int guard = 0;
        int seen = 0;
        while (got_q.size() < 1 && guard < 500) begin
          @(posedge aclk);
          #1;
          guard++;
        end
        m_tready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge aclk);
          if (m_tvalid) begin
            seen++;
            check("stall_tready", 32'(s_tready), 32'd0);
          end
        end
        check("stall_seen", 32'(seen > 0), 32'd1);
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    check("bp_n", 32'(got_q.size()), 32'd7);
    compare_model("bp");

    // Asynchronous reset mid-symbol.
    do_reset();
    for (int i = 0; i < 30; i++) send((i % 2 == 0) ? -23'sd5 : 23'sd5, 1'b0);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_outs", 32'({m_tvalid, m_tlast, m_tdata, sym_count, err_len}), 32'd0);
    check("midrst_tready", 32'(s_tready), 32'd0);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk);
    #1;
    got_q.delete(); exp_q.delete(); exp_sym = 0; exp_err = 1'b0;
    run_symbol(64, 1'b1, 0);
    drain();
    compare_model("after_rst");

    // Random symbols with random downstream backpressure.
    do_reset();
    rnd_ready = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int len;
      logic tl;
      len = $urandom_range(1, N_SC);
      tl  = (len < N_SC) ? 1'b1 : 1'($urandom_range(0, 1));
      run_symbol(len, tl, 2);
    end
    rnd_ready = 1'b0;
    @(posedge aclk);
    #2;
    m_tready = 1'b1;
    drain();
    compare_model("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
